// File: rtl/pb_uart.sv
// ---------------------------------------------------------------------------
// pb_uart : UART with a programmable baud generator, a 16x8 TX FIFO and a
//           16x8 RX FIFO.
//           Frames are 8N1 (start 0, 8 data bits LSB first, stop 1).
//           Each bit lasts 16 ticks of the baud generator.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_i              asynchronous reset, active low
//   uart_baud_control  [0] baud generator enable
//   uart_baud_count    divisor N; one tick every N+1 clocks
//   uart_baud_status   [0] generator running, [1] one-cycle 16x tick
//   uart_tx_pad        serial transmit line, idle high
//   uart_tx_data       byte to enqueue for transmission
//   uart_tx_write      enqueue strobe
//   uart_tx_control    [0] TX enable, [1] TX irq enable,
//                      [2] RX irq enable, [3] clear error flags
//   uart_tx_int        TX FIFO empty interrupt (level)
//   uart_fifo_status   {0, tx_busy, framing_error, rx_overrun,
//                       rx_full, rx_empty, tx_full, tx_empty}
//   uart_rx_pad        serial receive line, asynchronous to clk_i
//   uart_rx_data       head of the RX FIFO (first-word fall-through)
//   uart_rx_read       pop strobe
//   uart_rx_int        RX FIFO not-empty interrupt (level)
// ---------------------------------------------------------------------------
module pb_uart (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] uart_baud_control,
  input  logic [7:0] uart_baud_count,
  output logic [7:0] uart_baud_status,
  output logic       uart_tx_pad,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_write,
  input  logic [7:0] uart_tx_control,
  output logic       uart_tx_int,
  output logic [7:0] uart_fifo_status,
  input  logic       uart_rx_pad,
  output logic [7:0] uart_rx_data,
  input  logic       uart_rx_read,
  output logic       uart_rx_int
);

  localparam int DATA_W  = 8;
  localparam int FIFO_AW = 4;
  localparam int FIFO_D  = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // -------------------------------------------------------------------------
  // Baud generator
  // -------------------------------------------------------------------------
  logic [7:0] r_baud_cnt;
  logic [7:0] r_baud_div;
  logic       r_baud_run;
  logic       r_tick;
  logic       w_baud_en;
  logic       w_baud_wrap;

  assign w_baud_en = uart_baud_control[0];
  // ">=" rather than "==" so a counter that is somehow above the divisor
  // still wraps instead of running the long way round.
  assign w_baud_wrap = w_baud_en && (r_baud_cnt >= r_baud_div);

  // The divisor is sampled only at a wrap (or while stopped), so a new
  // setting never truncates the period in progress.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_baud_cnt <= '0;
      r_baud_div <= '0;
      r_baud_run <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_baud_run <= w_baud_en;
      r_tick     <= w_baud_wrap;
      if (!w_baud_en || w_baud_wrap) begin
        r_baud_cnt <= '0;
        r_baud_div <= uart_baud_count;
      end else begin
        r_baud_cnt <= r_baud_cnt + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // TX FIFO
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_txf_mem [FIFO_D];
  logic [FIFO_AW-1:0] r_txf_wr;
  logic [FIFO_AW-1:0] r_txf_rd;
  logic [FIFO_AW:0]   r_txf_cnt;
  logic               w_tx_empty;
  logic               w_tx_full;
  logic               w_txf_push;
  logic               w_txf_pop;
  logic [DATA_W-1:0]  w_txf_head;

  assign w_tx_empty = (r_txf_cnt == '0);
  assign w_tx_full  = (r_txf_cnt == 5'(FIFO_D));
  assign w_txf_push = uart_tx_write && !w_tx_full;
  assign w_txf_head = r_txf_mem[r_txf_rd];

  // Storage is never observable before its first write, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (w_txf_push) begin
      r_txf_mem[r_txf_wr] <= uart_tx_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_txf_wr  <= '0;
      r_txf_rd  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_txf_push) r_txf_wr <= r_txf_wr + 4'd1;
      if (w_txf_pop)  r_txf_rd <= r_txf_rd + 4'd1;
      case ({w_txf_push, w_txf_pop})
        2'b10:   r_txf_cnt <= r_txf_cnt + 5'd1;
        2'b01:   r_txf_cnt <= r_txf_cnt - 5'd1;
        default: r_txf_cnt <= r_txf_cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // TX state machine
  // -------------------------------------------------------------------------
  tx_state_t         r_tx_state;
  tx_state_t         w_tx_state_nxt;
  logic [3:0]        r_tx_tcnt;
  logic [3:0]        w_tx_tcnt_nxt;
  logic [2:0]        r_tx_bcnt;
  logic [2:0]        w_tx_bcnt_nxt;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] w_tx_shift_nxt;
  logic              r_tx_pad;
  logic              w_tx_pad_nxt;
  logic              w_tx_go;

  // Enable gates only the start of a new frame; a frame in flight finishes.
  assign w_tx_go = !w_tx_empty && uart_tx_control[0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_shift <= '0;
      r_tx_pad   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_tcnt  <= w_tx_tcnt_nxt;
      r_tx_bcnt  <= w_tx_bcnt_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_pad   <= w_tx_pad_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tcnt_nxt  = r_tx_tcnt;
    w_tx_bcnt_nxt  = r_tx_bcnt;
    w_tx_shift_nxt = r_tx_shift;
    w_txf_pop      = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_tick && w_tx_go) begin
          w_tx_state_nxt = TX_START;
          w_tx_tcnt_nxt  = '0;
          w_tx_shift_nxt = w_txf_head;
          w_txf_pop      = 1'b1;
        end
      end
      TX_START: begin
        if (r_tick) begin
          w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            w_tx_state_nxt = TX_DATA;
            w_tx_bcnt_nxt  = '0;
          end
        end
      end
      TX_DATA: begin
        if (r_tick) begin
          w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_W-1:1]};
            if (r_tx_bcnt == 3'd7) begin
              w_tx_state_nxt = TX_STOP;
            end else begin
              w_tx_bcnt_nxt = r_tx_bcnt + 3'd1;
            end
          end
        end
      end
      TX_STOP: begin
        if (r_tick) begin
          w_tx_tcnt_nxt = r_tx_tcnt + 4'd1;
          if (r_tx_tcnt == 4'd15) begin
            // Chain straight into the next start bit: no idle gap.
            if (w_tx_go) begin
              w_tx_state_nxt = TX_START;
              w_tx_shift_nxt = w_txf_head;
              w_txf_pop      = 1'b1;
            end else begin
              w_tx_state_nxt = TX_IDLE;
            end
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase

    // Pad is registered from the next state so it never glitches.
    case (w_tx_state_nxt)
      TX_START: w_tx_pad_nxt = 1'b0;
      TX_DATA:  w_tx_pad_nxt = w_tx_shift_nxt[0];
      default:  w_tx_pad_nxt = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // RX synchronizer and state machine
  // -------------------------------------------------------------------------
  logic              r_rx_s1;
  logic              r_rx_s2;
  logic              r_rx_prev;
  logic              w_rx_fall;
  rx_state_t         r_rx_state;
  rx_state_t         w_rx_state_nxt;
  logic [3:0]        r_rx_tcnt;
  logic [3:0]        w_rx_tcnt_nxt;
  logic [2:0]        r_rx_bcnt;
  logic [2:0]        w_rx_bcnt_nxt;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] w_rx_shift_nxt;
  logic              w_rx_done;
  logic              w_ferr_set;

  assign w_rx_fall = r_rx_prev && !r_rx_s2;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= uart_rx_pad;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_tcnt  <= w_rx_tcnt_nxt;
      r_rx_bcnt  <= w_rx_bcnt_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tcnt_nxt  = r_rx_tcnt;
    w_rx_bcnt_nxt  = r_rx_bcnt;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_done      = 1'b0;
    w_ferr_set     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_nxt = RX_START;
          w_rx_tcnt_nxt  = '0;
        end
      end
      RX_START: begin
        if (r_tick) begin
          w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
          // Eighth tick: centre of the start bit.
          if (r_rx_tcnt == 4'd7) begin
            w_rx_tcnt_nxt = '0;
            w_rx_bcnt_nxt = '0;
            w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (r_tick) begin
          w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd15) begin
            w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_W-1:1]};
            if (r_rx_bcnt == 3'd7) begin
              w_rx_state_nxt = RX_STOP;
            end else begin
              w_rx_bcnt_nxt = r_rx_bcnt + 3'd1;
            end
          end
        end
      end
      RX_STOP: begin
        if (r_tick) begin
          w_rx_tcnt_nxt = r_rx_tcnt + 4'd1;
          if (r_rx_tcnt == 4'd15) begin
            w_rx_state_nxt = RX_IDLE;
            if (r_rx_s2) begin
              w_rx_done = 1'b1;
            end else begin
              w_ferr_set = 1'b1;
            end
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // RX FIFO and error flags
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_rxf_mem [FIFO_D];
  logic [FIFO_AW-1:0] r_rxf_wr;
  logic [FIFO_AW-1:0] r_rxf_rd;
  logic [FIFO_AW:0]   r_rxf_cnt;
  logic               w_rx_empty;
  logic               w_rx_full;
  logic               w_rxf_push;
  logic               w_rxf_pop;
  logic               w_ovr_set;
  logic               w_err_clr;
  logic               r_rx_ovr;
  logic               r_rx_ferr;

  assign w_rx_empty = (r_rxf_cnt == '0);
  assign w_rx_full  = (r_rxf_cnt == 5'(FIFO_D));
  assign w_rxf_push = w_rx_done && !w_rx_full;
  assign w_ovr_set  = w_rx_done && w_rx_full;
  assign w_rxf_pop  = uart_rx_read && !w_rx_empty;
  assign w_err_clr  = uart_tx_control[3];

  // Storage is reset because its head is visible on uart_rx_data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < FIFO_D; i++) begin
        r_rxf_mem[i] <= '0;
      end
      r_rxf_wr  <= '0;
      r_rxf_rd  <= '0;
      r_rxf_cnt <= '0;
      r_rx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      if (w_rxf_push) begin
        r_rxf_mem[r_rxf_wr] <= r_rx_shift;
        r_rxf_wr            <= r_rxf_wr + 4'd1;
      end
      if (w_rxf_pop) r_rxf_rd <= r_rxf_rd + 4'd1;
      case ({w_rxf_push, w_rxf_pop})
        2'b10:   r_rxf_cnt <= r_rxf_cnt + 5'd1;
        2'b01:   r_rxf_cnt <= r_rxf_cnt - 5'd1;
        default: r_rxf_cnt <= r_rxf_cnt;
      endcase
      // A new error in the same cycle as a clear must not be lost.
      if (w_ovr_set)      r_rx_ovr <= 1'b1;
      else if (w_err_clr) r_rx_ovr <= 1'b0;
      if (w_ferr_set)     r_rx_ferr <= 1'b1;
      else if (w_err_clr) r_rx_ferr <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic w_tx_busy;
  logic w_unused;

  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign w_unused  = ^{uart_baud_control[7:1], uart_tx_control[7:4]};

  assign uart_baud_status = {6'b0, r_tick, r_baud_run};
  assign uart_tx_pad      = r_tx_pad;
  assign uart_rx_data     = r_rxf_mem[r_rxf_rd];
  assign uart_fifo_status = {1'b0, w_tx_busy, r_rx_ferr, r_rx_ovr,
                             w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
  // Interrupt enables are raw inputs, so reset also masks the outputs.
  assign uart_tx_int = rst_i && w_tx_empty && uart_tx_control[1];
  assign uart_rx_int = rst_i && !w_rx_empty && uart_tx_control[2];

endmodule

// File: tb/tb_pb_uart.sv
module tb_pb_uart;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] baud_control;
  logic [7:0] baud_count;
  logic [7:0] baud_status;
  logic       tx_pad;
  logic [7:0] tx_data;
  logic       tx_write;
  logic [7:0] tx_control;
  logic       tx_int;
  logic [7:0] fifo_status;
  logic       rx_pad;
  logic       rx_drv;
  logic       loop_en;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       rx_int;

  int errors = 0;
  int checks = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [9:0] obs_q[$];

  always #10 clk = ~clk;

  assign rx_pad = loop_en ? tx_pad : rx_drv;

  pb_uart dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .uart_baud_control (baud_control),
    .uart_baud_count   (baud_count),
    .uart_baud_status  (baud_status),
    .uart_tx_pad       (tx_pad),
    .uart_tx_data      (tx_data),
    .uart_tx_write     (tx_write),
    .uart_tx_control   (tx_control),
    .uart_tx_int       (tx_int),
    .uart_fifo_status  (fifo_status),
    .uart_rx_pad       (rx_pad),
    .uart_rx_data      (rx_data),
    .uart_rx_read      (rx_read),
    .uart_rx_int       (rx_int)
  );

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic set_baud(input logic [7:0] n);
    @(negedge clk);
    baud_control = 8'h00;
    baud_count   = n;
    @(negedge clk);
    baud_control = 8'h01;
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic read_rx();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  // Drives one 8N1 frame onto rx_drv, 32 clocks per bit (N=1).
  task automatic send_frame(input logic [7:0] d, input logic stopb);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (32) @(negedge clk);
    end
    rx_drv = stopb;
    repeat (32) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  // Watches tx_pad from the first busy cycle until busy drops; pushes each
  // decoded 10-bit frame (bit0 = start) to obs_q, counts busy cycles and
  // pad changes that fall off a bit boundary.
  task automatic tx_monitor(input int bitclk, input int limit,
                            output int busy_cyc, output int glitches);
    int         w;
    int         k;
    logic       prev;
    logic [9:0] fr;
    busy_cyc = 0;
    glitches = 0;
    w = 0;
    fr = '0;
    @(negedge clk);
    while (fifo_status[6] !== 1'b1 && w < limit) begin
      @(negedge clk);
      w++;
    end
    if (fifo_status[6] !== 1'b1) return;
    k = 0;
    prev = tx_pad;
    while (fifo_status[6] === 1'b1 && k < limit) begin
      if (k > 0 && tx_pad !== prev && (k % bitclk) != 0) glitches++;
      prev = tx_pad;
      if ((k % bitclk) == bitclk / 2) fr[(k / bitclk) % 10] = tx_pad;
      if ((k % (10 * bitclk)) == 10 * bitclk - 1) obs_q.push_back(fr);
      k++;
      @(negedge clk);
    end
    busy_cyc = k;
  endtask

  // ---------------------------- tests ----------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    baud_control = 8'h00; baud_count = 8'h00;
    tx_data = 8'h00; tx_write = 1'b0; rx_read = 1'b0;
    tx_control = 8'h06; rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_pad !== 1'b1) begin errors++; $display("FAIL reset_tx_pad got=%b exp=1", tx_pad); end
    checks++; if (fifo_status !== 8'h05) begin errors++; $display("FAIL reset_fifo_status got=%h exp=05", fifo_status); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (baud_status !== 8'h00) begin errors++; $display("FAIL reset_baud_status got=%h exp=00", baud_status); end
    checks++; if (tx_int !== 1'b0 || rx_int !== 1'b0) begin errors++; $display("FAIL reset_ints got=%b%b exp=00", tx_int, rx_int); end
    tx_control = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_baud();
    int n;
    int ticks;
    set_baud(8'd3);
    repeat (2) @(negedge clk);
    checks++; if (baud_status[0] !== 1'b1) begin errors++; $display("FAIL baud_running got=%b exp=1", baud_status[0]); end
    n = 0;
    while (baud_status[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (baud_status[1] !== 1'b0) begin errors++; $display("FAIL baud_tick_width got=%b exp=0", baud_status[1]); end
    n = 1;
    while (baud_status[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL baud_tick_period got=%0d exp=4", n); end
    baud_control = 8'h00;
    repeat (2) @(negedge clk);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (baud_status[1] === 1'b1) ticks++;
      @(negedge clk);
    end
    checks++; if (ticks !== 0 || baud_status[0] !== 1'b0) begin errors++; $display("FAIL baud_disabled ticks=%0d run=%b exp=0,0", ticks, baud_status[0]); end
  endtask

  task automatic test_tx_frame();
    int busy;
    int gl;
    logic [7:0] e;
    set_baud(8'd26);
    tx_control = 8'h00;
    write_tx(8'hA5);
    tx_q.push_back(8'hA5);
    tx_control = 8'h01;
    tx_monitor(432, 6000, busy, gl);
    checks++; if (busy !== 4320) begin errors++; $display("FAIL tx_frame_busy_cycles got=%0d exp=4320", busy); end
    checks++; if (gl !== 0) begin errors++; $display("FAIL tx_frame_bit_timing off_boundary_edges=%0d exp=0", gl); end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL tx_frame_count got=%0d exp=1", obs_q.size());
    end else begin
      e = tx_q.pop_front();
      if (obs_q[0] !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL tx_frame_bits got=%b exp=%b", obs_q[0], {1'b1, e, 1'b0}); end
    end
    obs_q.delete();
    checks++; if (fifo_status[6] !== 1'b0 || fifo_status[0] !== 1'b1) begin errors++; $display("FAIL tx_frame_idle busy=%b empty=%b exp=0,1", fifo_status[6], fifo_status[0]); end
  endtask

  task automatic test_back_to_back();
    int busy;
    int gl;
    logic [7:0] e;
    set_baud(8'd1);
    tx_control = 8'h00;
    write_tx(8'h11); tx_q.push_back(8'h11);
    write_tx(8'hC3); tx_q.push_back(8'hC3);
    write_tx(8'h7E); tx_q.push_back(8'h7E);
    tx_control = 8'h01;
    tx_monitor(32, 3000, busy, gl);
    checks++; if (busy !== 960) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=960", busy); end
    checks++; if (gl !== 0) begin errors++; $display("FAIL b2b_bit_timing off_boundary_edges=%0d exp=0", gl); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_frame_count got=%0d exp=3", obs_q.size()); end
    while (obs_q.size() > 0 && tx_q.size() > 0) begin
      e = tx_q.pop_front();
      checks++; if (obs_q[0] !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL b2b_frame got=%b exp=%b", obs_q[0], {1'b1, e, 1'b0}); end
      void'(obs_q.pop_front());
    end
    tx_q.delete();
    obs_q.delete();
  endtask

  task automatic test_tx_fifo_full();
    int busy;
    int gl;
    int cnt;
    int highs;
    logic [7:0] e;
    tx_control = 8'h00;
    cnt = 0;
    for (int i = 0; i <= 16; i++) begin
      write_tx(8'(i));
      if (cnt < 16) begin tx_q.push_back(8'(i)); cnt++; end
      if (i == 14) begin
        checks++; if (fifo_status[1] !== 1'b0) begin errors++; $display("FAIL fifo_full_early got=%b exp=0", fifo_status[1]); end
      end
      if (i == 15 || i == 16) begin
        checks++; if (fifo_status[1] !== 1'b1) begin errors++; $display("FAIL fifo_full_flag write=%0d got=%b exp=1", i, fifo_status[1]); end
      end
    end
    tx_control = 8'h01;
    tx_monitor(32, 8000, busy, gl);
    checks++; if (busy !== 5120) begin errors++; $display("FAIL fifo_busy_cycles got=%0d exp=5120", busy); end
    checks++; if (obs_q.size() != 16) begin errors++; $display("FAIL fifo_frame_count got=%0d exp=16", obs_q.size()); end
    while (obs_q.size() > 0 && tx_q.size() > 0) begin
      e = tx_q.pop_front();
      checks++; if (obs_q[0] !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL fifo_frame got=%b exp=%b", obs_q[0], {1'b1, e, 1'b0}); end
      void'(obs_q.pop_front());
    end
    highs = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_pad === 1'b1) highs++;
      @(negedge clk);
    end
    checks++; if (highs !== 400 || fifo_status[0] !== 1'b1) begin errors++; $display("FAIL fifo_no_extra_frame high_cycles=%0d empty=%b exp=400,1", highs, fifo_status[0]); end
    tx_q.delete();
    obs_q.delete();
  endtask

  task automatic test_loopback();
    int w;
    logic [7:0] e;
    loop_en = 1'b1;
    tx_control = 8'h05;
    write_tx(8'h3C);
    rx_q.push_back(8'h3C);
    w = 0;
    while (fifo_status[2] !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
    checks++; if (fifo_status[2] !== 1'b0) begin errors++; $display("FAIL loop_rx_not_empty got=%b exp=0", fifo_status[2]); end
    e = rx_q.pop_front();
    checks++; if (rx_data !== e) begin errors++; $display("FAIL loop_rx_data got=%h exp=%h", rx_data, e); end
    checks++; if (rx_int !== 1'b1) begin errors++; $display("FAIL loop_rx_int got=%b exp=1", rx_int); end
    read_rx();
    checks++; if (fifo_status[2] !== 1'b1 || rx_int !== 1'b0) begin errors++; $display("FAIL loop_after_read empty=%b int=%b exp=1,0", fifo_status[2], rx_int); end
    repeat (100) @(negedge clk);
    loop_en = 1'b0;
    tx_control = 8'h00;
  endtask

  task automatic test_rx_overrun();
    int cnt;
    logic [7:0] e;
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'h40 + 8'(i), 1'b1);
      if (cnt < 16) begin rx_q.push_back(8'h40 + 8'(i)); cnt++; end
    end
    repeat (8) @(negedge clk);
    checks++; if (fifo_status[3] !== 1'b1) begin errors++; $display("FAIL ovr_rx_full got=%b exp=1", fifo_status[3]); end
    checks++; if (fifo_status[4] !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", fifo_status[4]); end
    while (rx_q.size() > 0) begin
      e = rx_q.pop_front();
      checks++; if (rx_data !== e) begin errors++; $display("FAIL ovr_readback got=%h exp=%h", rx_data, e); end
      read_rx();
    end
    checks++; if (fifo_status[2] !== 1'b1 || fifo_status[3] !== 1'b0) begin errors++; $display("FAIL ovr_drained empty=%b full=%b exp=1,0", fifo_status[2], fifo_status[3]); end
    checks++; if (fifo_status[4] !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", fifo_status[4]); end
    tx_control = 8'h08;
    @(negedge clk);
    tx_control = 8'h00;
    checks++; if (fifo_status[4] !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", fifo_status[4]); end
  endtask

  task automatic test_rx_errors();
    logic [7:0] e;
    send_frame(8'h5A, 1'b0);
    repeat (32) @(negedge clk);
    checks++; if (fifo_status[5] !== 1'b1) begin errors++; $display("FAIL ferr_set got=%b exp=1", fifo_status[5]); end
    checks++; if (fifo_status[2] !== 1'b1) begin errors++; $display("FAIL ferr_fifo_unchanged empty=%b exp=1", fifo_status[2]); end
    tx_control = 8'h08;
    @(negedge clk);
    tx_control = 8'h00;
    checks++; if (fifo_status[5] !== 1'b0) begin errors++; $display("FAIL ferr_clear got=%b exp=0", fifo_status[5]); end
    // low glitch of 3 ticks (6 clocks at N=1)
    rx_drv = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    checks++; if (fifo_status[2] !== 1'b1 || fifo_status[5] !== 1'b0) begin errors++; $display("FAIL glitch_ignored empty=%b ferr=%b exp=1,0", fifo_status[2], fifo_status[5]); end
    send_frame(8'h81, 1'b1);
    rx_q.push_back(8'h81);
    repeat (8) @(negedge clk);
    e = rx_q.pop_front();
    checks++; if (fifo_status[2] !== 1'b0 || rx_data !== e) begin errors++; $display("FAIL rx_after_errors empty=%b data=%h exp=0,%h", fifo_status[2], rx_data, e); end
    read_rx();
  endtask

  task automatic test_reset_midframe();
    int w;
    tx_control = 8'h01;
    write_tx(8'h00);
    w = 0;
    while (fifo_status[6] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    repeat (80) @(negedge clk);
    checks++; if (fifo_status[6] !== 1'b1 || tx_pad !== 1'b0) begin errors++; $display("FAIL midframe_precond busy=%b pad=%b exp=1,0", fifo_status[6], tx_pad); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_pad !== 1'b1) begin errors++; $display("FAIL midframe_reset_pad got=%b exp=1", tx_pad); end
    checks++; if (fifo_status !== 8'h05) begin errors++; $display("FAIL midframe_reset_status got=%h exp=05", fifo_status); end
    checks++; if (baud_status !== 8'h00 || rx_data !== 8'h00) begin errors++; $display("FAIL midframe_reset_misc baud=%h rxd=%h exp=00,00", baud_status, rx_data); end
    tx_control = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_baud();
    test_tx_frame();
    test_back_to_back();
    test_tx_fifo_full();
    test_loopback();
    test_rx_overrun();
    test_rx_errors();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
